dct_8_stage_2_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 8-point DCT stage-2 butterfly in the visc_DCT accelerator, behind the cohort fifo_controller acc_unit.
- Processes GROUPS independent 8-lane vectors per beat.
- Uses a valid/ready handshake with true backpressure, a fixed 2-cycle latency and a beat counter.
- Drops in wherever the combinational stage sat between stage 1 and stage 3.

---
 rtl/dct_8_stage_2_pipe_if.sv | 28 ++
 rtl/dct_8_stage_2_pipe.sv | 143 ++++++++++++++
 tb/tb_dct_8_stage_2_pipe.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_8_stage_2_pipe_if.sv
// Handshake bundle for dct_8_stage_2_pipe.
// The sticky o_sat flag exists only when DCT_STAGE2_SAT_EN is defined.
interface dct_8_stage_2_pipe_if #(
    parameter int W      = 64,
    parameter int GROUPS = 1,
    parameter int CNT_W  = 32
);
    logic [GROUPS*8*W-1:0] i_data_in;
    logic                  i_valid;
    logic                  i_ready;
    logic [GROUPS*8*W-1:0] o_data_out;
    logic                  o_valid;
    logic                  o_ready;
    logic [CNT_W-1:0]      o_beat_cnt;
`ifdef DCT_STAGE2_SAT_EN
    logic                  o_sat;

    modport master (output i_data_in, i_valid, o_ready,
                    input  i_ready, o_data_out, o_valid, o_beat_cnt, o_sat);
    modport slave  (input  i_data_in, i_valid, o_ready,
                    output i_ready, o_data_out, o_valid, o_beat_cnt, o_sat);
`else
    modport master (output i_data_in, i_valid, o_ready,
                    input  i_ready, o_data_out, o_valid, o_beat_cnt);
    modport slave  (input  i_data_in, i_valid, o_ready,
                    output i_ready, o_data_out, o_valid, o_beat_cnt);
`endif
endinterface

// File: rtl/dct_8_stage_2_pipe.sv
// Two-register pipelined 8-point DCT stage-2 butterfly over GROUPS lanes-of-8 per beat.
// Define DCT_STAGE2_SAT_EN for saturating arithmetic plus a sticky o_sat flag; default wraps modulo 2^W.
module dct_8_stage_2_pipe #(
    parameter int W      = 64,
    parameter int GROUPS = 1,
    parameter int CNT_W  = 32
) (
    input logic                  clk,
    input logic                  rst,
    dct_8_stage_2_pipe_if.slave  bus
);
    localparam int VW = GROUPS * 8 * W;

`ifdef DCT_STAGE2_SAT_EN
    function automatic logic signed [W:0] lane_wide(input logic signed [W-1:0] a, b, input logic sub);
        logic signed [W:0] ae;
        logic signed [W:0] be;
        ae = {a[W-1], a};
        be = {b[W-1], b};
        return sub ? ae - be : ae + be;
    endfunction

    // Top two bits disagree exactly when the W+1-bit result leaves the W-bit range.
    function automatic logic signed [W-1:0] lane_op(input logic signed [W-1:0] a, b, input logic sub);
        logic signed [W:0] s;
        s = lane_wide(a, b, sub);
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
    endfunction

    function automatic logic lane_clip(input logic signed [W-1:0] a, b, input logic sub);
        logic signed [W:0] s;
        s = lane_wide(a, b, sub);
        return s[W] ^ s[W-1];
    endfunction
`else
    function automatic logic signed [W-1:0] lane_op(input logic signed [W-1:0] a, b, input logic sub);
        return sub ? a - b : a + b;
    endfunction
`endif

    function automatic logic [8*W-1:0] bfly(input logic [8*W-1:0] v);
        logic signed [W-1:0] x [8];
        for (int k = 0; k < 8; k++) x[k] = v[k*W +: W];
        return {x[7],
                lane_op(x[6], x[7], 1'b0), lane_op(x[5], x[6], 1'b0), lane_op(x[4], x[5], 1'b0),
                lane_op(x[0], x[3], 1'b1), lane_op(x[1], x[2], 1'b1),
                lane_op(x[1], x[2], 1'b0), lane_op(x[0], x[3], 1'b0)};
    endfunction

`ifdef DCT_STAGE2_SAT_EN
    function automatic logic bfly_clip(input logic [8*W-1:0] v);
        logic signed [W-1:0] x [8];
        for (int k = 0; k < 8; k++) x[k] = v[k*W +: W];
        return lane_clip(x[0], x[3], 1'b0) | lane_clip(x[1], x[2], 1'b0) |
               lane_clip(x[1], x[2], 1'b1) | lane_clip(x[0], x[3], 1'b1) |
               lane_clip(x[4], x[5], 1'b0) | lane_clip(x[5], x[6], 1'b0) |
               lane_clip(x[6], x[7], 1'b0);
    endfunction
`endif

    logic [VW-1:0]    data_p0_q, data_p0_d;
    logic [VW-1:0]    data_p1_q, data_p1_d;
    logic [VW-1:0]    f_data;
    logic             vld_p0_q, vld_p0_d;
    logic             vld_p1_q, vld_p1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv_a, adv_b, push;

    // Readiness ripples back from o_ready only; i_valid never feeds i_ready.
    assign adv_b = !vld_p1_q || bus.o_ready;
    assign adv_a = !vld_p0_q || adv_b;
    assign push  = bus.i_valid && bus.i_ready;

    assign bus.i_ready    = adv_a && !rst;
    assign bus.o_data_out = data_p1_q;
    assign bus.o_valid    = vld_p1_q;
    assign bus.o_beat_cnt = cnt_q;

    always_comb begin
        f_data = '0;
        for (int g = 0; g < GROUPS; g++)
            f_data[g*8*W +: 8*W] = bfly(data_p0_q[g*8*W +: 8*W]);
    end

    always_comb begin
        data_p0_d = data_p0_q;
        data_p1_d = data_p1_q;
        vld_p0_d  = vld_p0_q;
        vld_p1_d  = vld_p1_q;
        cnt_d     = cnt_q;
        // stage B: butterfly result
        if (adv_b) begin
            vld_p1_d = vld_p0_q;
            if (vld_p0_q) data_p1_d = f_data;
        end
        // stage A: raw input capture
        if (adv_a) begin
            vld_p0_d = bus.i_valid;
            if (bus.i_valid) data_p0_d = bus.i_data_in;
        end
        if (push) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_p0_q <= '0;
            data_p1_q <= '0;
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            data_p0_q <= data_p0_d;
            data_p1_q <= data_p1_d;
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef DCT_STAGE2_SAT_EN
    logic clip_any;
    logic sat_q, sat_d;

    always_comb begin
        clip_any = 1'b0;
        for (int g = 0; g < GROUPS; g++)
            clip_any = clip_any | bfly_clip(data_p0_q[g*8*W +: 8*W]);
    end

    always_comb begin
        sat_d = sat_q | (adv_b && vld_p0_q && clip_any);
    end

    always_ff @(posedge clk) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= sat_d;
    end

    assign bus.o_sat = sat_q;
`endif
endmodule

// File: tb/tb_dct_8_stage_2_pipe.sv
// Scoreboard bench for dct_8_stage_2_pipe: a W=16 GROUPS=2 instance for data paths and a
// CNT_W=4 instance for counter wrap; expectations follow DCT_STAGE2_SAT_EN when it is defined.
module tb_dct_8_stage_2_pipe;
    localparam int W  = 16;
    localparam int G  = 2;
    localparam int VW = G * 8 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dct_8_stage_2_pipe_if #(.W(W), .GROUPS(G), .CNT_W(32)) bus ();
    dct_8_stage_2_pipe_if #(.W(W), .GROUPS(1), .CNT_W(4))  bus_w ();

    dct_8_stage_2_pipe #(.W(W), .GROUPS(G), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    dct_8_stage_2_pipe #(.W(W), .GROUPS(1), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w.slave));

    int checks   = 0;
    int failures = 0;
    logic [VW-1:0] sb [$];

    function automatic logic [15:0] ref_op(input int a, input int b, input bit sub);
        int r;
        r = sub ? a - b : a + b;
`ifdef DCT_STAGE2_SAT_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] d);
        logic [VW-1:0] o;
        int x [8];
        o = '0;
        for (int g = 0; g < G; g++) begin
            for (int k = 0; k < 8; k++) x[k] = int'($signed(d[(g*8+k)*16 +: 16]));
            o[(g*8+0)*16 +: 16] = ref_op(x[0], x[3], 1'b0);
            o[(g*8+1)*16 +: 16] = ref_op(x[1], x[2], 1'b0);
            o[(g*8+2)*16 +: 16] = ref_op(x[1], x[2], 1'b1);
            o[(g*8+3)*16 +: 16] = ref_op(x[0], x[3], 1'b1);
            o[(g*8+4)*16 +: 16] = ref_op(x[4], x[5], 1'b0);
            o[(g*8+5)*16 +: 16] = ref_op(x[5], x[6], 1'b0);
            o[(g*8+6)*16 +: 16] = ref_op(x[6], x[7], 1'b0);
            o[(g*8+7)*16 +: 16] = x[7][15:0];
        end
        return o;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] d;
        for (int j = 0; j < VW/32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock of stimulus; handshakes are resolved #1 after the falling edge.
    task automatic step(input logic v, input logic [VW-1:0] d, input logic rdy,
                        output logic acc, output logic fire, output logic [VW-1:0] od);
        @(negedge clk);
        bus.i_valid   = v;
        bus.i_data_in = d;
        bus.o_ready   = rdy;
        #1;
        acc  = v && bus.i_ready;
        fire = bus.o_valid && rdy;
        od   = bus.o_data_out;
        if (acc) sb.push_back(ref_vec(d));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b0;   bus.o_ready = 1'b1;
        bus_w.i_valid = 1'b0; bus_w.o_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus.i_ready !== 1'b0) begin failures++; $display("FAIL rst_iready_low got=%b exp=0", bus.i_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.i_ready !== 1'b1) begin failures++; $display("FAIL rst_iready_high got=%b exp=1", bus.i_ready); end
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_beat_cnt !== 32'd0 || bus.o_data_out !== '0) begin
            failures++;
            $display("FAIL rst_state valid=%b cnt=%0d data=%h exp all zero", bus.o_valid, bus.o_beat_cnt, bus.o_data_out);
        end
`ifdef DCT_STAGE2_SAT_EN
        checks++;
        if (bus.o_sat !== 1'b0) begin failures++; $display("FAIL rst_sat got=%b exp=0", bus.o_sat); end
`endif
    endtask

    task automatic test_basic();
        logic acc, fire;
        logic [VW-1:0] od, d, expv;
        int lanes_in [8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
        int lanes_out [8] = '{5, 5, -1, -3, 11, 13, 15, 8};
        apply_reset();
        d = '0; expv = '0;
        for (int k = 0; k < 8; k++) begin
            d[k*16 +: 16]    = 16'(lanes_in[k]);
            expv[k*16 +: 16] = 16'(lanes_out[k]);
        end
        step(1'b1, d, 1'b1, acc, fire, od);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", acc); end
        step(1'b0, '0, 1'b1, acc, fire, od);
        checks++;
        if (fire !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", fire); end
        step(1'b0, '0, 1'b1, acc, fire, od);
        checks++;
        if (fire !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", fire); end
        checks++;
        if (od !== expv) begin failures++; $display("FAIL basic_data got=%h exp=%h", od, expv); end
        checks++;
        if (bus.o_beat_cnt !== 32'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", bus.o_beat_cnt); end
        sb.delete();
    endtask

    task automatic test_stream();
        logic acc, fire;
        logic [VW-1:0] od, expd;
        int nout = 0;
        int not_ready = 0;
        apply_reset();
        for (int i = 0; i < 20 + 6; i++) begin
            step(i < 20, rand_vec(), 1'b1, acc, fire, od);
            if (i < 20 && !acc) not_ready++;
            if (fire) begin
                checks++;
                nout++;
                if (sb.size() == 0) begin failures++; $display("FAIL stream_extra got=%h", od); end
                else begin
                    expd = sb.pop_front();
                    if (od !== expd) begin failures++; $display("FAIL stream_data got=%h exp=%h", od, expd); end
                end
            end
        end
        checks++;
        if (not_ready != 0) begin failures++; $display("FAIL stream_iready stalls=%0d exp=0", not_ready); end
        checks++;
        if (nout != 20 || sb.size() != 0) begin failures++; $display("FAIL stream_count got=%0d left=%0d exp=20", nout, sb.size()); end
        checks++;
        if (bus.o_beat_cnt !== 32'd20) begin failures++; $display("FAIL stream_cnt got=%0d exp=20", bus.o_beat_cnt); end
    endtask

    task automatic test_backpressure();
        logic acc0, acc1, acc2, acc3, acc4, fire;
        logic [VW-1:0] od, hold1, hold2, expd, a, b, c;
        int nout = 0;
        apply_reset();
        a = rand_vec(); b = rand_vec(); c = rand_vec();
        step(1'b1, a, 1'b0, acc0, fire, od);
        step(1'b1, b, 1'b0, acc1, fire, od);
        step(1'b1, c, 1'b0, acc2, fire, hold1);
        step(1'b1, c, 1'b0, acc3, fire, hold2);
        checks++;
        if ({acc0, acc1, acc2, acc3} !== 4'b1100) begin
            failures++; $display("FAIL bp_accepts got=%b exp=1100", {acc0, acc1, acc2, acc3});
        end
        checks++;
        if (hold1 !== hold2 || hold1 !== sb[0]) begin
            failures++; $display("FAIL bp_hold got=%h then=%h exp=%h", hold1, hold2, sb[0]);
        end
        step(1'b1, c, 1'b1, acc4, fire, od);
        checks++;
        if (acc4 !== 1'b1) begin failures++; $display("FAIL bp_third_accept got=%b exp=1", acc4); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(1'b0, '0, 1'b1, acc4, fire, od);
            if (fire) begin
                checks++;
                nout++;
                if (sb.size() == 0) begin failures++; $display("FAIL bp_extra got=%h", od); end
                else begin
                    expd = sb.pop_front();
                    if (od !== expd) begin failures++; $display("FAIL bp_data got=%h exp=%h", od, expd); end
                end
            end
        end
        checks++;
        if (nout != 3 || bus.o_beat_cnt !== 32'd3) begin
            failures++; $display("FAIL bp_count outs=%0d cnt=%0d exp=3", nout, bus.o_beat_cnt);
        end
    endtask

    task automatic test_overflow();
        logic acc, fire, seen;
        logic [VW-1:0] od, d, expd;
        logic [15:0] e_y0, e_y3, e_g1y2;
        apply_reset();
        d = '0;
        d[0*16 +: 16]     = 16'h7fff;
        d[3*16 +: 16]     = 16'h0001;
        d[(8+1)*16 +: 16] = 16'h8000;
        d[(8+2)*16 +: 16] = 16'h0001;
`ifdef DCT_STAGE2_SAT_EN
        e_y0 = 16'h7fff; e_y3 = 16'h7ffe; e_g1y2 = 16'h8000;
`else
        e_y0 = 16'h8000; e_y3 = 16'h7ffe; e_g1y2 = 16'h7fff;
`endif
        step(1'b1, d, 1'b1, acc, fire, od);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1'b0, '0, 1'b1, acc, fire, od);
            seen = fire;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL ovf_timeout got=none exp=one beat"); end
        else begin
            checks++;
            if (od[0*16 +: 16] !== e_y0 || od[3*16 +: 16] !== e_y3 || od[(8+2)*16 +: 16] !== e_g1y2) begin
                failures++;
                $display("FAIL ovf_lanes y0=%h y3=%h g1y2=%h exp %h %h %h",
                         od[0*16 +: 16], od[3*16 +: 16], od[(8+2)*16 +: 16], e_y0, e_y3, e_g1y2);
            end
            expd = sb.pop_front();
            checks++;
            if (od !== expd) begin failures++; $display("FAIL ovf_vector got=%h exp=%h", od, expd); end
`ifdef DCT_STAGE2_SAT_EN
            checks++;
            if (bus.o_sat !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", bus.o_sat); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic acc, fire;
        logic [VW-1:0] od;
        int stale = 0;
        apply_reset();
        step(1'b1, rand_vec(), 1'b0, acc, fire, od);
        step(1'b1, rand_vec(), 1'b0, acc, fire, od);
        @(negedge clk);
        rst = 1'b1;
        bus.i_valid = 1'b0;
        #1;
        checks++;
        if (bus.i_ready !== 1'b0) begin failures++; $display("FAIL mid_iready got=%b exp=0", bus.i_ready); end
        @(negedge clk);
        rst = 1'b0;
        bus.o_ready = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_beat_cnt !== 32'd0 || bus.o_data_out !== '0) begin
            failures++;
            $display("FAIL mid_state valid=%b cnt=%0d data=%h exp all zero", bus.o_valid, bus.o_beat_cnt, bus.o_data_out);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, acc, fire, od);
            if (fire) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_cnt_wrap();
        int stalls = 0;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus_w.i_valid   = 1'b1;
            bus_w.i_data_in = {4{$urandom}};
            bus_w.o_ready   = 1'b1;
            #1;
            if (!bus_w.i_ready) stalls++;
            if (i == 16) begin
                checks++;
                if (bus_w.o_beat_cnt !== 4'd0) begin failures++; $display("FAIL wrap_at16 got=%0d exp=0", bus_w.o_beat_cnt); end
            end
        end
        @(negedge clk);
        bus_w.i_valid = 1'b0;
        #1;
        checks++;
        if (bus_w.o_beat_cnt !== 4'd1 || stalls != 0) begin
            failures++; $display("FAIL wrap_cnt got=%0d stalls=%0d exp=1 stalls=0", bus_w.o_beat_cnt, stalls);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.i_valid = 1'b0;   bus.i_data_in = '0;   bus.o_ready = 1'b1;
        bus_w.i_valid = 1'b0; bus_w.i_data_in = '0; bus_w.o_ready = 1'b1;
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
